// File: rtl/fft_frame_feeder_pkg.sv
// Shared types and helpers for the FFT frame feeder and its surroundings.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: default frame geometry, complex sample type, feeder FSM
// state encoding and a bit-reversal helper for bin reordering.
package fft_frame_feeder_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_DATA_W = 32;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  // Reverse the low log2n bits of k; log2n must be a constant when used in logic.
  function automatic int unsigned bitrev(input int unsigned k, input int unsigned log2n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < log2n; i++) begin
      r = (r << 1) | ((k >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_feeder_if.sv
// Bundle of the feeder's sample input stream, parallel core bus and bin output stream.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the bin side.
//
// Ports (slave = feeder view):
//   in_valid/in_ready/in_re/in_im          sample stream into the feeder
//   fft_en/fft_x/fft_y                     frame and enable driven to the core
//   fft_xout/fft_yout                      core results, sample k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready/out_re/out_im/out_idx/out_last   bin stream out of the feeder
//   busy                                   feeder is not accepting samples (WAIT or DRAIN)
interface fft_frame_feeder_if #(
  parameter int N      = fft_frame_feeder_pkg::FFT_N,
  parameter int DATA_W = fft_frame_feeder_pkg::FFT_DATA_W
);
  localparam int IDX_W = $clog2(N);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;

  logic                     fft_en;
  logic [N*DATA_W-1:0]      fft_x;
  logic [N*DATA_W-1:0]      fft_y;
  logic [N*DATA_W-1:0]      fft_xout;
  logic [N*DATA_W-1:0]      fft_yout;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;

  logic                     busy;

  modport slave (
    input  in_valid, in_re, in_im, fft_xout, fft_yout, out_ready,
    output in_ready, fft_en, fft_x, fft_y, out_valid, out_re, out_im, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_re, in_im, fft_xout, fft_yout, out_ready,
    input  in_ready, fft_en, fft_x, fft_y, out_valid, out_re, out_im, out_idx, out_last, busy
  );

endinterface

// File: rtl/fft_frame_feeder.sv
// Collects N streamed complex samples, presents them in parallel to the FFT core, captures its result, streams N bins out.
// Latency: last sample handshake at edge t -> fft_en high after edges t..t+FFT_LATENCY-1, first bin valid after edge t+FFT_LATENCY.
// Backpressure: in_ready is low for the whole WAIT/DRAIN phase (no frame overlap); bins hold stable while out_ready is low.
//
// Ports: clk (rising edge), reset (async, active low), bus (fft_frame_feeder_if.slave).
module fft_frame_feeder
  import fft_frame_feeder_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter int FFT_LATENCY = 16,
  parameter bit OUT_BITREV  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  fft_frame_feeder_if.slave bus
);

  localparam int DATA_W = FFT_DATA_W;
  localparam int IDX_W  = $clog2(N);
  localparam int LAT_W  = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(FFT_LATENCY - 1);

  state_t           state;
  logic [IDX_W-1:0] fill_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic [LAT_W-1:0] lat_cnt;

  // Whole frame and whole result are registers: the core consumes and
  // produces all N points in parallel, so a RAM would not help.
  cplx_t frame  [N];
  cplx_t result [N];

  logic             in_ready_q;
  logic             fft_en_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [IDX_W-1:0] out_idx_q;
  cplx_t            out_bin_q;

  logic [IDX_W-1:0] rd_nxt;

  // Result slot that feeds output bin k.
  function automatic logic [IDX_W-1:0] src_idx(input logic [IDX_W-1:0] k);
    if (OUT_BITREV) begin
      return IDX_W'(bitrev(32'(k), IDX_W));
    end
    return k;
  endfunction

  always_comb begin
    rd_nxt = rd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_FILL;
      fill_cnt    <= '0;
      rd_cnt      <= '0;
      lat_cnt     <= '0;
      for (int k = 0; k < N; k++) begin
        frame[k]  <= '0;
        result[k] <= '0;
      end
      in_ready_q  <= 1'b0;
      fft_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_bin_q   <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            frame[fill_cnt] <= cplx_t'{re: bus.in_re, im: bus.in_im};
            if (fill_cnt == LAST_IDX) begin
              fill_cnt   <= '0;
              lat_cnt    <= '0;
              in_ready_q <= 1'b0;
              fft_en_q   <= 1'b1;
              state      <= ST_WAIT;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (lat_cnt == LAST_LAT) begin
            for (int k = 0; k < N; k++) begin
              result[k].re <= bus.fft_xout[k*DATA_W +: DATA_W];
              result[k].im <= bus.fft_yout[k*DATA_W +: DATA_W];
            end
            // Bin 0 reads slot 0 in both natural and bit-reversed order,
            // so it can be loaded straight from the core bus.
            out_bin_q.re <= bus.fft_xout[0 +: DATA_W];
            out_bin_q.im <= bus.fft_yout[0 +: DATA_W];
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b1;
            rd_cnt       <= '0;
            lat_cnt      <= '0;
            fft_en_q     <= 1'b0;
            state        <= ST_DRAIN;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              rd_cnt      <= '0;
              in_ready_q  <= 1'b1;
              state       <= ST_FILL;
            end else begin
              rd_cnt     <= rd_nxt;
              out_idx_q  <= rd_nxt;
              out_last_q <= (rd_nxt == LAST_IDX);
              out_bin_q  <= result[src_idx(rd_nxt)];
            end
          end
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_frame_bus
    assign bus.fft_x[k*DATA_W +: DATA_W] = frame[k].re;
    assign bus.fft_y[k*DATA_W +: DATA_W] = frame[k].im;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.fft_en    = fft_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_bin_q.re;
  assign bus.out_im    = out_bin_q.im;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != ST_FILL);

endmodule
